// File: rtl/eth_tx_frame_fifo.sv
// eth_tx_frame_fifo
// Store-and-forward transmit buffer for the Ethernet TX path. Frame bytes come in
// as contiguous runs of valid_in. Each frame is held until it is complete, then it
// is serialised LSB-first onto an OUT_W-bit axiov/axiod stream. At least IFG_CYCLES
// idle cycles follow every frame.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   valid_in  byte_in valid; a contiguous high run is one frame
//   byte_in   frame byte
//   axiov     axiod valid
//   axiod     output symbol; bits [OUT_W-1:0] of each byte go out first
//   full      buffer holds DEPTH entries
//   overflow  one-cycle pulse for each byte dropped because the buffer was full
//   level     number of entries currently stored
module eth_tx_frame_fifo #(
    parameter int DEPTH      = 128,
    parameter int OUT_W      = 2,
    parameter int IFG_CYCLES = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [7:0]             byte_in,
    output logic                   axiov,
    output logic [OUT_W-1:0]       axiod,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int SYMS = 8 / OUT_W;
    localparam int SCW  = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int GW   = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t state, state_next;

    logic [7:0]       mem_data [DEPTH];
    logic [DEPTH-1:0] mem_last;

    logic [PW-1:0]  wr_ptr, rd_ptr, frame_cnt;
    logic           staged_valid, cur_stored;
    logic [7:0]     staged_data;
    logic [7:0]     rd_q, shreg;
    logic           rd_q_last, cur_last;
    logic [SCW-1:0] sym_cnt;
    logic [GW-1:0]  gap_cnt;

    logic wr_req, wr_last, wr_ok, drop, tag_fix, frame_inc, frame_dec, rd_en;
    logic first_sym, last_sym, ent_last;
    logic [AW-1:0] wr_addr, wr_addr_prev, rd_addr;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PW'(DEPTH));

    // Write side. The staged byte is written on every edge where it exists. It is
    // tagged last when valid_in has dropped. A write into a full buffer only goes
    // ahead if the reader pops an entry on the same edge. A dropped closing byte
    // moves the last tag onto the newest entry of the frame that was stored.
    always_comb begin
        wr_req       = staged_valid;
        wr_last      = !valid_in;
        wr_ok        = wr_req && (!full || rd_en);
        drop         = wr_req && !wr_ok;
        tag_fix      = drop && wr_last && cur_stored;
        frame_inc    = wr_req && wr_last && (wr_ok || cur_stored);
        wr_addr      = wr_ptr[AW-1:0];
        wr_addr_prev = wr_addr - 1'b1;
        rd_addr      = rd_ptr[AW-1:0];
    end

    // Entry storage (data plus last tag) and the registered read port.
    // A read never targets the entry being written or re-tagged, because only
    // completed frames are read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_data[wr_addr] <= staged_data;
            mem_last[wr_addr] <= wr_last;
        end else if (tag_fix) begin
            mem_last[wr_addr_prev] <= 1'b1;
        end
        if (rd_en) begin
            rd_q      <= mem_data[rd_addr];
            rd_q_last <= mem_last[rd_addr];
        end
    end

    // Pointers, staging register, completed-frame count and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frame_cnt    <= '0;
            staged_valid <= 1'b0;
            staged_data  <= '0;
            cur_stored   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            staged_valid <= valid_in;
            if (valid_in) staged_data <= byte_in;
            if (wr_req && wr_last) cur_stored <= 1'b0;
            else if (wr_ok)        cur_stored <= 1'b1;
            overflow <= drop;
            case ({frame_inc, frame_dec})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state. GAP lasts IFG_CYCLES-1 cycles. The LOAD cycle that follows is
    // also idle on the output, so back-to-back frames get exactly IFG_CYCLES idle
    // cycles between them.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (frame_cnt != '0) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: if (last_sym && ent_last) state_next = (IFG_CYCLES == 1) ? IDLE : GAP;
            GAP:  if (int'(gap_cnt) == IFG_CYCLES - 2)
                      state_next = (frame_cnt != '0) ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and read control. The first symbol of every entry comes straight
    // from the RAM output register. The read of the next entry is issued in that
    // same cycle, which keeps the symbols of a frame gapless even when SYMS is 1.
    always_comb begin
        first_sym = (sym_cnt == '0);
        last_sym  = (sym_cnt == SCW'(SYMS - 1));
        ent_last  = first_sym ? rd_q_last : cur_last;
        axiov     = (state == SEND);
        axiod     = '0;
        if (state == SEND) axiod = first_sym ? rd_q[OUT_W-1:0] : shreg[OUT_W-1:0];
        rd_en     = (state == LOAD) || ((state == SEND) && first_sym && !rd_q_last);
        frame_dec = (state == SEND) && last_sym && ent_last;
    end

    // Serialiser shift register, symbol counter and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            cur_last <= 1'b0;
            sym_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == SEND) begin
                sym_cnt <= last_sym ? '0 : sym_cnt + 1'b1;
                if (first_sym) begin
                    shreg    <= rd_q >> OUT_W;
                    cur_last <= rd_q_last;
                end else begin
                    shreg <= shreg >> OUT_W;
                end
            end else begin
                sym_cnt <= '0;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// tb_eth_tx_frame_fifo
// Drives four buffer configurations and checks them:
//   u_a DEPTH=128 OUT_W=2 IFG=48
//   u_b DEPTH=16  OUT_W=2 IFG=48
//   u_c DEPTH=16  OUT_W=8 IFG=4
//   u_d DEPTH=16  OUT_W=1 IFG=4
// When a frame is written, the bytes that should come out are queued per instance.
// A negedge monitor rebuilds bytes from the symbols and pops the queue to compare.
// It also tracks burst lengths, gap lengths and overflow pulses.
module tb_eth_tx_frame_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       vin [4];
    logic [7:0] bin [4];

    logic a_v, a_full, a_ovf; logic [1:0] a_d; logic [7:0] a_lvl;
    logic b_v, b_full, b_ovf; logic [1:0] b_d; logic [4:0] b_lvl;
    logic c_v, c_full, c_ovf; logic [7:0] c_d; logic [4:0] c_lvl;
    logic d_v, d_full, d_ovf; logic [0:0] d_d; logic [4:0] d_lvl;

    logic       ov [4], fl [4], ovf [4];
    logic [7:0] od [4], lvl [4];

    int pass_cnt = 0, total_cnt = 0, cyc = 0;
    logic [7:0] q0 [$], q1 [$], q2 [$], q3 [$];
    logic [7:0] fr [$];

    int nsym [4], run_len [4], low_len [4], last_burst [4], last_gap [4];
    int burst_count [4], starts [4], hi_cnt [4], rise_cyc [4], ovf_cnt [4];
    int out_bytes [4], wr_cnt [4], fall_cyc [4];
    logic [7:0] acc [4];
    bit in_burst [4], gap_valid [4];
    bit lvl_chk_en = 1'b0;
    int wr_base = 0, out_base = 0;

    eth_tx_frame_fifo #(.DEPTH(128), .OUT_W(2), .IFG_CYCLES(48)) u_a (
        .clk(clk), .rst(rst), .valid_in(vin[0]), .byte_in(bin[0]), .axiov(a_v),
        .axiod(a_d), .full(a_full), .overflow(a_ovf), .level(a_lvl));
    eth_tx_frame_fifo #(.DEPTH(16), .OUT_W(2), .IFG_CYCLES(48)) u_b (
        .clk(clk), .rst(rst), .valid_in(vin[1]), .byte_in(bin[1]), .axiov(b_v),
        .axiod(b_d), .full(b_full), .overflow(b_ovf), .level(b_lvl));
    eth_tx_frame_fifo #(.DEPTH(16), .OUT_W(8), .IFG_CYCLES(4)) u_c (
        .clk(clk), .rst(rst), .valid_in(vin[2]), .byte_in(bin[2]), .axiov(c_v),
        .axiod(c_d), .full(c_full), .overflow(c_ovf), .level(c_lvl));
    eth_tx_frame_fifo #(.DEPTH(16), .OUT_W(1), .IFG_CYCLES(4)) u_d (
        .clk(clk), .rst(rst), .valid_in(vin[3]), .byte_in(bin[3]), .axiov(d_v),
        .axiod(d_d), .full(d_full), .overflow(d_ovf), .level(d_lvl));

    always #5 clk = ~clk;

    // Cycle counter used to measure output latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Collect all instance outputs into arrays so one monitor loop can serve them.
    always_comb begin
        ov[0] = a_v; od[0] = {6'd0, a_d}; fl[0] = a_full; ovf[0] = a_ovf; lvl[0] = a_lvl;
        ov[1] = b_v; od[1] = {6'd0, b_d}; fl[1] = b_full; ovf[1] = b_ovf; lvl[1] = {3'd0, b_lvl};
        ov[2] = c_v; od[2] = c_d;         fl[2] = c_full; ovf[2] = c_ovf; lvl[2] = {3'd0, c_lvl};
        ov[3] = d_v; od[3] = {7'd0, d_d}; fl[3] = d_full; ovf[3] = d_ovf; lvl[3] = {3'd0, d_lvl};
    end

    function automatic int ow_of(input int k);
        case (k)
            0, 1:    return 2;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        total_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic push_exp(input int k, input logic [7:0] b);
        case (k)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            2:       q2.push_back(b);
            default: q3.push_back(b);
        endcase
    endtask

    task automatic flush_exp(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            2:       q2.delete();
            default: q3.delete();
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop_exp(input int k, output logic [7:0] b, output bit ok);
        ok = (q_size(k) != 0);
        b  = 8'h00;
        if (ok) begin
            case (k)
                0:       b = q0.pop_front();
                1:       b = q1.pop_front();
                2:       b = q2.pop_front();
                default: b = q3.pop_front();
            endcase
        end
    endtask

    // Monitor: rebuild bytes LSB-first, compare them with the scoreboard, and
    // measure bursts, gaps and overflow pulses.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                flush_exp(k);
                acc[k] = 8'h00; nsym[k] = 0; in_burst[k] = 1'b0;
                low_len[k] = 0; gap_valid[k] = 1'b0;
            end else begin
                if (!ov[k]) checkOutput("axiod_zero_when_idle", od[k], 0);
                if (ovf[k]) ovf_cnt[k]++;
                if (ov[k]) begin
                    if (!in_burst[k]) begin
                        rise_cyc[k] = cyc;
                        if (gap_valid[k]) last_gap[k] = low_len[k];
                        in_burst[k] = 1'b1; run_len[k] = 0; starts[k]++;
                    end
                    run_len[k]++; hi_cnt[k]++;
                    acc[k] = acc[k] | 8'(od[k] << (nsym[k] * ow_of(k)));
                    nsym[k]++;
                    if (nsym[k] * ow_of(k) == 8) begin
                        logic [7:0] e;
                        bit ok;
                        pop_exp(k, e, ok);
                        if (!ok) checkOutput("unexpected_byte", acc[k], -1);
                        else     checkOutput("byte_data", acc[k], e);
                        out_bytes[k]++;
                        acc[k] = 8'h00; nsym[k] = 0;
                    end
                end else begin
                    if (in_burst[k]) begin
                        last_burst[k] = run_len[k]; burst_count[k]++;
                        in_burst[k] = 1'b0; low_len[k] = 0; gap_valid[k] = 1'b1;
                    end
                    low_len[k]++;
                end
                // Read-ahead keeps up to two entries popped but not yet fully sent.
                if (k == 1 && lvl_chk_en)
                    checkRange("level_model", lvl[1],
                               (wr_cnt[1] - wr_base) - (out_bytes[1] - out_base) - 2,
                               (wr_cnt[1] - wr_base) - (out_bytes[1] - out_base));
            end
        end
    end

    // Drive the bytes in fr as one frame into instance k, and queue the first
    // nexp of them as expected output.
    task automatic applyStimulus(input int k, input int nexp);
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            vin[k] = 1'b1; bin[k] = fr[i];
            if (i < nexp) push_exp(k, fr[i]);
            @(posedge clk); #1;
            if (i > 0) wr_cnt[k]++;
        end
        @(negedge clk);
        vin[k] = 1'b0; bin[k] = 8'h00;
        @(posedge clk); #1;
        wr_cnt[k]++;
        fall_cyc[k] = cyc;
    endtask

    // Wait with a cycle budget. sel selects the counter: 0 = bursts, 1 = starts, 2 = valid cycles.
    task automatic wait_until(input int k, input int sel, input int target, input int budget);
        int n = 0;
        int v;
        v = (sel == 0) ? burst_count[k] : (sel == 1) ? starts[k] : hi_cnt[k];
        while (v < target && n < budget) begin
            @(posedge clk); n++;
            v = (sel == 0) ? burst_count[k] : (sel == 1) ? starts[k] : hi_cnt[k];
        end
        if (v < target) checkOutput("wait_timeout", v, target);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h, bc, sb;
        for (int k = 0; k < 4; k++) begin
            vin[k] = 1'b0; bin[k] = 8'h00; nsym[k] = 0; run_len[k] = 0; low_len[k] = 0;
            last_burst[k] = 0; last_gap[k] = 0; burst_count[k] = 0; starts[k] = 0;
            hi_cnt[k] = 0; rise_cyc[k] = 0; ovf_cnt[k] = 0; out_bytes[k] = 0;
            wr_cnt[k] = 0; fall_cyc[k] = 0; acc[k] = 8'h00;
            in_burst[k] = 1'b0; gap_valid[k] = 1'b0;
        end

        // Reset state of every instance.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("reset_axiov", ov[k], 0);
            checkOutput("reset_axiod", od[k], 0);
            checkOutput("reset_full", fl[k], 0);
            checkOutput("reset_overflow", ovf[k], 0);
            checkOutput("reset_level", lvl[k], 0);
        end
        #1 rst = 1'b0;

        // 84 bytes of 0xD2 give 336 contiguous symbols 10,00,01,11 repeating.
        $display("[TB] long 0xD2 frame");
        fr.delete();
        repeat (84) fr.push_back(8'hD2);
        applyStimulus(0, 84);
        checkOutput("t1_level_after_frame", lvl[0], 84);
        wait_until(0, 0, 1, 2000);
        checkOutput("t1_burst_len", last_burst[0], 336);
        checkOutput("t1_latency", rise_cyc[0] - fall_cyc[0], 2);
        checkOutput("t1_level_drained", lvl[0], 0);

        // Two 10-byte frames one idle cycle apart.
        $display("[TB] back-to-back frames");
        fr.delete();
        for (int i = 0; i < 10; i++) fr.push_back(8'(8'h10 + i));
        applyStimulus(0, 10);
        fr.delete();
        for (int i = 0; i < 10; i++) fr.push_back(8'(8'h20 + i));
        applyStimulus(0, 10);
        wait_until(0, 0, 2, 1000);
        checkOutput("t2_burst1_len", last_burst[0], 40);
        checkOutput("t2_gap_after_t1", last_gap[0], 48);
        wait_until(0, 0, 3, 1000);
        checkOutput("t2_burst2_len", last_burst[0], 40);
        checkOutput("t2_gap_between", last_gap[0], 48);

        // 20-byte frame into a 16-entry buffer: 4 drops, 16 bytes are sent.
        $display("[TB] oversize frame");
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'(i));
        applyStimulus(1, 16);
        checkOutput("t3_full_when_stalled", fl[1], 1);
        checkOutput("t3_level_stalled", lvl[1], 16);
        wait_until(1, 0, 1, 1000);
        checkOutput("t3_burst_len", last_burst[1], 64);
        checkOutput("t3_latency", rise_cyc[1] - fall_cyc[1], 2);
        checkOutput("t3_overflow_pulses", ovf_cnt[1], 4);
        fr.delete();
        fr.push_back(8'h55); fr.push_back(8'h66); fr.push_back(8'h77);
        applyStimulus(1, 3);
        wait_until(1, 0, 2, 1000);
        checkOutput("t3_next_burst_len", last_burst[1], 12);
        checkOutput("t3_no_more_overflow", ovf_cnt[1], 4);
        checkOutput("t3_not_full", fl[1], 0);

        // Reset mid-send with a second frame queued.
        $display("[TB] reset during send");
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'(8'h30 + i));
        applyStimulus(0, 20);
        fr.delete();
        for (int i = 0; i < 5; i++) fr.push_back(8'(8'h50 + i));
        applyStimulus(0, 5);
        wait_until(0, 2, hi_cnt[0] + 10, 500);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("t4_axiov_at_reset", ov[0], 0);
        checkOutput("t4_level_at_reset", lvl[0], 0);
        #1 rst = 1'b0;
        h  = hi_cnt[0];
        bc = burst_count[0];
        repeat (150) @(posedge clk);
        #1;
        checkOutput("t4_silent_after_reset", hi_cnt[0], h);
        checkOutput("t4_level_after_reset", lvl[0], 0);
        fr.delete();
        for (int i = 1; i <= 4; i++) fr.push_back(8'(i));
        applyStimulus(0, 4);
        wait_until(0, 0, bc + 1, 500);
        checkOutput("t4_new_burst_len", last_burst[0], 16);
        checkOutput("t4_new_latency", rise_cyc[0] - fall_cyc[0], 2);

        // Byte-wide and bit-serial output widths.
        $display("[TB] OUT_W 8 and 1");
        fr.delete();
        fr.push_back(8'hA5); fr.push_back(8'h3C); fr.push_back(8'hFF);
        applyStimulus(2, 3);
        wait_until(2, 0, 1, 200);
        checkOutput("t5_w8_burst_len", last_burst[2], 3);
        checkOutput("t5_w8_latency", rise_cyc[2] - fall_cyc[2], 2);
        applyStimulus(3, 3);
        wait_until(3, 0, 1, 200);
        checkOutput("t5_w1_burst_len", last_burst[3], 24);
        checkOutput("t5_w1_latency", rise_cyc[3] - fall_cyc[3], 2);

        // Writes overlapping reads, 56 bytes through a 16-entry buffer.
        $display("[TB] concurrent traffic across wrap");
        wr_base = wr_cnt[1];
        out_base = out_bytes[1];
        bc = burst_count[1];
        sb = starts[1];
        lvl_chk_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            fr.delete();
            for (int i = 0; i < 7; i++) fr.push_back(8'(((f * 7 + i) * 37 + 5) & 255));
            applyStimulus(1, 7);
            wait_until(1, 1, sb + f + 1, 400);
        end
        wait_until(1, 0, bc + 8, 600);
        lvl_chk_en = 1'b0;
        checkOutput("t6_last_burst_len", last_burst[1], 28);
        checkOutput("t6_level_drained", lvl[1], 0);
        checkOutput("t6_no_overflow", ovf_cnt[1], 4);

        repeat (5) @(posedge clk);
        for (int k = 0; k < 4; k++) checkOutput("scoreboard_empty", q_size(k), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
